puf_seq_ctrl: RTL and testbench

Sequencer that drives one PUF evaluation end to end. It accepts a challenge request over a valid/ready handshake and clears the PUF scan chain. It then serialises the challenge into the chain, runs NREP arm/settle/sample evaluations, and majority-votes the sampled `out` bit. It sits between the on-chip request source (logic-analyzer or Wishbone shim) and `puf_top`, and owns every `puf_top` control pin: `reset`, `puf_sel`, `clk`, `si`, `rstn` and `length`.

---
 rtl/puf_ctrl_pkg.sv | 12 +
 rtl/puf_seq_ctrl_if.sv | 18 +
 rtl/puf_chal_ser.sv | 56 +++++
 rtl/puf_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_puf_seq_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/puf_ctrl_pkg.sv
// puf_ctrl_pkg: shared state type, length codes and helpers for the PUF sequencer
package puf_ctrl_pkg;
    localparam int CHAL_MAX = 128;
    localparam logic [1:0] LEN_32  = 2'd0;
    localparam logic [1:0] LEN_64  = 2'd1;
    localparam logic [1:0] LEN_128 = 2'd2;
    localparam logic [1:0] LEN_ILL = 2'd3;
    typedef enum logic [2:0] {IDLE, CLR, SHIFT, ARM, SETTLE, SAMPLE, RESP} state_t;
    function automatic logic [7:0] len_bits(input logic [1:0] code);
        return code == LEN_32 ? 8'd32 : code == LEN_64 ? 8'd64 : code == LEN_128 ? 8'd128 : 8'd0;
    endfunction
endpackage

// File: rtl/puf_seq_ctrl_if.sv
// puf_seq_ctrl_if: request/response handshake bundle between a requester and the PUF sequencer
interface puf_seq_ctrl_if;
    import puf_ctrl_pkg::*;
    logic                req_valid;
    logic                req_ready;
    logic [CHAL_MAX-1:0] req_chal;
    logic [1:0]          req_len;
    logic [1:0]          req_sel;
    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_bit;
    logic [3:0]          rsp_ones;
    logic                rsp_err;
    modport master (output req_valid, req_chal, req_len, req_sel, rsp_ready,
                    input  req_ready, rsp_valid, rsp_bit, rsp_ones, rsp_err);
    modport slave  (input  req_valid, req_chal, req_len, req_sel, rsp_ready,
                    output req_ready, rsp_valid, rsp_bit, rsp_ones, rsp_err);
endinterface

// File: rtl/puf_chal_ser.sv
// puf_chal_ser: MSB-first challenge serialiser with a two-phase scan clock
module puf_chal_ser
    import puf_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rstn,
    input  logic                load,
    input  logic [CHAL_MAX-1:0] chal,
    input  logic [7:0]          nbits,
    output logic                done,
    output logic                si,
    output logic                sclk
);
    logic [CHAL_MAX-1:0] sreg_q, sreg_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                si_q, si_d, sclk_q, sclk_d;
    // Load left-justifies the active bits; each bit then spends one cycle with sclk low and one high
    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        si_d   = si_q;
        sclk_d = sclk_q;
        if (load) begin
            sreg_d = chal << (8'(CHAL_MAX) - nbits);
            si_d   = sreg_d[CHAL_MAX-1];
            cnt_d  = nbits;
            sclk_d = 1'b0;
        end else if (sclk_q) begin
            sclk_d = 1'b0;
            if (cnt_q != 8'd0) begin
                sreg_d = sreg_q << 1;
                si_d   = sreg_q[CHAL_MAX-2];
            end
        end else if (cnt_q != 8'd0) begin
            sclk_d = 1'b1;
            cnt_d  = cnt_q - 8'd1;
        end
    end
    // Serialiser state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            si_q   <= 1'b0;
            sclk_q <= 1'b0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
            si_q   <= si_d;
            sclk_q <= sclk_d;
        end
    end
    assign done = sclk_q && cnt_q == 8'd0;
    assign si   = si_q;
    assign sclk = sclk_q;
endmodule

// File: rtl/puf_seq_ctrl.sv
// puf_seq_ctrl: runs one PUF evaluation (clear, shift, NREP arm/settle/sample) and majority-votes the result
module puf_seq_ctrl
    import puf_ctrl_pkg::*;
#(
    parameter int NREP       = 7,
    parameter int RST_CYC    = 4,
    parameter int SETTLE_CYC = 16
) (
    input  logic       clk,
    input  logic       rstn,
    puf_seq_ctrl_if.slave bus,
    output logic       puf_reset,
    output logic [1:0] puf_sel,
    output logic [1:0] puf_length,
    output logic       puf_clk,
    output logic       puf_si,
    output logic       puf_rstn,
    input  logic       puf_out
);
    state_t              state_q, state_d;
    logic [15:0]         cyc_q, cyc_d;
    logic [3:0]          eval_q, eval_d, ones_q, ones_d;
    logic [CHAL_MAX-1:0] chal_q, chal_d;
    logic [1:0]          len_q, len_d, sel_q, sel_d, sync_q, sync_d;
    logic                err_q, err_d;
    logic                req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
    logic                rsp_bit_q, rsp_bit_d, rsp_err_q, rsp_err_d;
    logic [3:0]          rsp_ones_q, rsp_ones_d;
    logic                puf_reset_q, puf_reset_d, puf_rstn_q, puf_rstn_d;
    logic                ser_load, ser_done;

    puf_chal_ser u_ser (
        .clk   (clk),
        .rstn  (rstn),
        .load  (ser_load),
        .chal  (chal_q),
        .nbits (len_bits(len_q)),
        .done  (ser_done),
        .si    (puf_si),
        .sclk  (puf_clk)
    );

    // Sequencing FSM; outputs are decoded from the next state so every pin leaves a flop
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        eval_d   = eval_q;
        ones_d   = ones_q;
        chal_d   = chal_q;
        len_d    = len_q;
        sel_d    = sel_q;
        err_d    = err_q;
        ser_load = 1'b0;
        sync_d   = {sync_q[0], puf_out};
        case (state_q)
            IDLE: if (bus.req_valid && req_ready_q) begin
                chal_d  = bus.req_chal;
                len_d   = bus.req_len;
                sel_d   = bus.req_sel;
                err_d   = bus.req_len == LEN_ILL;
                eval_d  = '0;
                ones_d  = '0;
                cyc_d   = '0;
                state_d = bus.req_len == LEN_ILL ? RESP : CLR;
            end
            CLR: if (cyc_q == 16'd1) begin
                state_d  = SHIFT;
                ser_load = 1'b1;
            end else cyc_d = cyc_q + 16'd1;
            SHIFT: if (ser_done) begin
                state_d = ARM;
                cyc_d   = '0;
            end
            ARM: if (cyc_q == 16'(RST_CYC - 1)) begin
                state_d = SETTLE;
                cyc_d   = '0;
            end else cyc_d = cyc_q + 16'd1;
            SETTLE: if (cyc_q == 16'(SETTLE_CYC - 1)) begin
                state_d = SAMPLE;
                cyc_d   = '0;
            end else cyc_d = cyc_q + 16'd1;
            SAMPLE: begin
                ones_d  = ones_q + {3'b000, sync_q[1]};
                eval_d  = eval_q + 4'd1;
                state_d = eval_d < 4'(NREP) ? ARM : RESP;
                cyc_d   = '0;
            end
            RESP: if (rsp_valid_q && bus.rsp_ready) begin
                state_d = IDLE;
                eval_d  = '0;
                ones_d  = '0;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = state_d == IDLE;
        rsp_valid_d = state_d == RESP;
        rsp_ones_d  = state_d == RESP ? ones_d : '0;
        rsp_bit_d   = state_d == RESP && ones_d > 4'(NREP / 2);
        rsp_err_d   = state_d == RESP && err_d;
        puf_reset_d = state_d == ARM;
        puf_rstn_d  = state_d != CLR;
    end

    // State, counters, captured request and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cyc_q       <= '0;
            eval_q      <= '0;
            ones_q      <= '0;
            chal_q      <= '0;
            len_q       <= '0;
            sel_q       <= '0;
            err_q       <= 1'b0;
            sync_q      <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_bit_q   <= 1'b0;
            rsp_ones_q  <= '0;
            rsp_err_q   <= 1'b0;
            puf_reset_q <= 1'b0;
            puf_rstn_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            eval_q      <= eval_d;
            ones_q      <= ones_d;
            chal_q      <= chal_d;
            len_q       <= len_d;
            sel_q       <= sel_d;
            err_q       <= err_d;
            sync_q      <= sync_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_bit_q   <= rsp_bit_d;
            rsp_ones_q  <= rsp_ones_d;
            rsp_err_q   <= rsp_err_d;
            puf_reset_q <= puf_reset_d;
            puf_rstn_q  <= puf_rstn_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_bit   = rsp_bit_q;
    assign bus.rsp_ones  = rsp_ones_q;
    assign bus.rsp_err   = rsp_err_q;
    assign puf_reset     = puf_reset_q;
    assign puf_rstn      = puf_rstn_q;
    assign puf_sel       = sel_q;
    assign puf_length    = len_q;
endmodule

// File: tb/tb_puf_seq_ctrl.sv
// tb_puf_seq_ctrl: scoreboard bench for puf_seq_ctrl driving a stub PUF
module tb_puf_seq_ctrl;
    import puf_ctrl_pkg::*;
    localparam int NREP = 7;

    typedef struct {
        logic         rbit;
        logic [3:0]   rones;
        logic         rerr;
        int           lat;
        int           n;
        logic [127:0] chal;
        int           acc;
        int           nclk0;
        int           nrst0;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic puf_reset, puf_clk, puf_si, puf_rstn;
    logic puf_out = 1'b0;
    logic [1:0] puf_sel, puf_length;
    logic [15:0] outs;
    int checks = 0, errors = 0, cnt = 0, nclk = 0, nrst = 0, rst_base = 0, k = 0;
    logic [127:0] sampled = '0;
    logic [6:0] pat = '0;
    logic [1:0] exp_sel = '0, exp_len = '0;
    exp_t sb[$];
    exp_t me;
    logic seen = 1'b0;
    int first = 0;
    logic [5:0] held = '0;
    logic [127:0] mask;

    puf_seq_ctrl_if bus();

    puf_seq_ctrl #(.NREP(NREP), .RST_CYC(4), .SETTLE_CYC(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .puf_reset  (puf_reset),
        .puf_sel    (puf_sel),
        .puf_length (puf_length),
        .puf_clk    (puf_clk),
        .puf_si     (puf_si),
        .puf_rstn   (puf_rstn),
        .puf_out    (puf_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 1;

    assign outs = {bus.req_ready, bus.rsp_valid, bus.rsp_bit, bus.rsp_ones, bus.rsp_err,
                   puf_reset, puf_clk, puf_si, puf_rstn, puf_sel, puf_length};

    // Stub PUF: records scan bits on each scan-clock rise, plays the response pattern per evaluation
    always @(posedge puf_clk) begin
        nclk++;
        sampled = {sampled[126:0], puf_si};
    end
    always @(posedge puf_reset) begin
        k = nrst - rst_base;
        puf_out = (k >= 0 && k < 7) ? pat[k[2:0]] : 1'b0;
        nrst++;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Instance select and length must only move at an acceptance
    always @(negedge clk) if (rstn) begin
        chk("puf_sel", 128'(puf_sel), 128'(exp_sel));
        chk("puf_length", 128'(puf_length), 128'(exp_len));
    end

    // Response monitor: hold checks while stalled, scoreboard compare on handshake
    always @(negedge clk) begin
        if (!rstn) seen = 1'b0;
        else if (bus.rsp_valid) begin
            if (!seen) begin
                seen  = 1'b1;
                first = cnt;
                held  = {bus.rsp_bit, bus.rsp_err, bus.rsp_ones};
            end else begin
                chk("rsp_hold", 128'({bus.rsp_bit, bus.rsp_err, bus.rsp_ones}), 128'(held));
                chk("req_ready_in_resp", 128'(bus.req_ready), 128'(0));
                chk("pins_hold", 128'({puf_clk, puf_reset, puf_rstn}), 128'(3'b001));
            end
            if (bus.rsp_ready) begin
                seen = 1'b0;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got response with empty scoreboard");
                end else begin
                    me = sb.pop_front();
                    chk("rsp_bit", 128'(bus.rsp_bit), 128'(me.rbit));
                    chk("rsp_ones", 128'(bus.rsp_ones), 128'(me.rones));
                    chk("rsp_err", 128'(bus.rsp_err), 128'(me.rerr));
                    chk("latency", 128'(first - me.acc + 1), 128'(me.lat));
                    chk("scan_edges", 128'(nclk - me.nclk0), 128'(me.n));
                    chk("arm_pulses", 128'(nrst - me.nrst0), 128'(me.rerr ? 0 : NREP));
                    if (me.n > 0) begin
                        mask = me.n == 128 ? '1 : (128'd1 << me.n) - 128'd1;
                        chk("scan_bits", sampled & mask, me.chal & mask);
                    end
                end
            end
        end
    end

    task automatic send(input logic [127:0] chal, input logic [1:0] len, input logic [1:0] sel,
                        input logic [6:0] p, input logic rb, input logic [3:0] ro, input logic re,
                        input int lat, input logic push);
        exp_t e;
        int t = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_chal  = chal;
        bus.req_len   = len;
        bus.req_sel   = sel;
        while (!bus.req_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("req_ready_before_accept", 128'(bus.req_ready), 128'(1));
        if (bus.req_ready) begin
            pat      = p;
            rst_base = nrst;
            e.rbit = rb; e.rones = ro; e.rerr = re; e.lat = lat;
            e.n = int'(len_bits(len)); e.chal = chal; e.acc = cnt + 1;
            e.nclk0 = nclk; e.nrst0 = nrst;
            if (push) sb.push_back(e);
            @(posedge clk);
            #1;
            exp_sel = sel;
            exp_len = len;
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (sb.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int base;
        bus.req_valid = 1'b0;
        bus.req_chal  = '0;
        bus.req_len   = '0;
        bus.req_sel   = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 128'(outs), 128'(0));
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", 128'({bus.req_ready, puf_rstn}), 128'(2'b11));

        send(128'hA5A5_0F0F, LEN_32, 2'd0, 7'h7F, 1'b1, 4'd7, 1'b0, 214, 1'b1);
        wait_done();
        send(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, LEN_128, 2'd3, 7'b0010101,
             1'b0, 4'd3, 1'b0, 406, 1'b1);
        wait_done();
        send(128'hFFFF, LEN_ILL, 2'd2, 7'h7F, 1'b0, 4'd0, 1'b1, 1, 1'b1);
        wait_done();

        bus.rsp_ready = 1'b0;
        send(128'hDEAD_BEEF_0BAD_F00D, LEN_64, 2'd1, 7'b1110011, 1'b1, 4'd5, 1'b0, 278, 1'b1);
        t = 0;
        while (!bus.rsp_valid && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("stall_rsp_valid", 128'(bus.rsp_valid), 128'(1));
        repeat (50) @(negedge clk);
        chk("stall_req_ready", 128'(bus.req_ready), 128'(0));
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_req_ready", 128'(bus.req_ready), 128'(1));
        chk("release_rsp_valid", 128'(bus.rsp_valid), 128'(0));
        wait_done();

        base = nclk;
        send(128'hCAFE_F00D_1357_9BDF, LEN_64, 2'd1, 7'h7F, 1'b1, 4'd7, 1'b0, 278, 1'b0);
        t = 0;
        while (nclk - base < 10 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("abort_point", 128'(nclk - base), 128'(10));
        #2 rstn = 1'b0;
        exp_sel = '0;
        exp_len = '0;
        #1 chk("abort_reset_outputs", 128'(outs), 128'(0));
        repeat (2) @(negedge clk);
        chk("abort_reset_hold", 128'(outs), 128'(0));
        rstn = 1'b1;
        send(128'h1234_5678, LEN_32, 2'd0, 7'b0000001, 1'b0, 4'd1, 1'b0, 214, 1'b1);
        wait_done();

        send(128'hFFFF_0000, LEN_32, 2'd1, 7'b1111000, 1'b1, 4'd4, 1'b0, 214, 1'b1);
        send(128'h0000_FFFF, LEN_32, 2'd2, 7'b0001111, 1'b1, 4'd4, 1'b0, 214, 1'b1);
        wait_done();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
